// File: rtl/remote_arm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : remote_arm_sequencer
// Description : Drives a low/high/low arm pattern on one channel while the other
//               channels sit at NEUTRAL, then passes user data through once armed.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_arm_sequencer #(
    parameter int               WIDTH       = 8,
    parameter int               CHANNELS    = 4,
    parameter int               ARM_CH      = 0,
    parameter int               PRE_CYCLES  = 16,
    parameter int               HIGH_CYCLES = 16,
    parameter int               POST_CYCLES = 16,
    parameter logic [WIDTH-1:0] NEUTRAL     = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        disarm,
    input  logic [CHANNELS*WIDTH-1:0]   pass_data,
    output logic [CHANNELS*WIDTH-1:0]   ch_out,
    output logic                        busy,
    output logic                        armed,
    output logic                        done
);

    localparam int c_MAX_PH_A  = (PRE_CYCLES > HIGH_CYCLES) ? PRE_CYCLES : HIGH_CYCLES;
    localparam int c_MAX_PHASE = (c_MAX_PH_A > POST_CYCLES) ? c_MAX_PH_A : POST_CYCLES;
    localparam int c_CNT_W     = $clog2(c_MAX_PHASE + 1);

    // Terminal counts: the counter runs 0..N-1 inside a phase, so it never wraps.
    localparam logic [c_CNT_W-1:0] c_PRE_LAST  = c_CNT_W'(PRE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HIGH_LAST = c_CNT_W'(HIGH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_POST_LAST = c_CNT_W'(POST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_HIGH  = 3'd2,
        S_POST  = 3'd3,
        S_ARMED = 3'd4
    } state_t;

    state_t                      r_state;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [CHANNELS*WIDTH-1:0]   w_safe;
    logic [CHANNELS*WIDTH-1:0]   w_high;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            if (k == ARM_CH) begin : g_arm
                assign w_safe[k*WIDTH +: WIDTH] = '0;
                assign w_high[k*WIDTH +: WIDTH] = '1;
            end else begin : g_neutral
                assign w_safe[k*WIDTH +: WIDTH] = NEUTRAL;
                assign w_high[k*WIDTH +: WIDTH] = NEUTRAL;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            ch_out  <= w_safe;
            busy    <= 1'b0;
            armed   <= 1'b0;
            done    <= 1'b0;
        end else if (disarm && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            ch_out  <= w_safe;
            busy    <= 1'b0;
            armed   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    ch_out <= w_safe;
                    if (start && !disarm) begin
                        r_state <= S_PRE;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (r_cnt == c_PRE_LAST) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        ch_out  <= w_high;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == c_HIGH_LAST) begin
                        r_state <= S_POST;
                        r_cnt   <= '0;
                        ch_out  <= w_safe;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_POST: begin
                    if (r_cnt == c_POST_LAST) begin
                        // Load pass_data on the entry edge so ARMED shows it with one-cycle latency.
                        r_state <= S_ARMED;
                        r_cnt   <= '0;
                        ch_out  <= pass_data;
                        busy    <= 1'b0;
                        armed   <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_ARMED: begin
                    ch_out <= pass_data;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    ch_out  <= w_safe;
                    busy    <= 1'b0;
                    armed   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_remote_arm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_remote_arm_sequencer
// Description : Directed bench for remote_arm_sequencer (default and 12x6 configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_arm_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        disarm;
    logic [31:0] pd;
    logic [31:0] ch_out;
    logic        busy, armed, done;

    logic        start2;
    logic [71:0] pd2;
    logic [71:0] ch_out2;
    logic        busy2, armed2, done2;

    int errors = 0;
    int checks = 0;

    remote_arm_sequencer dut (
        .clock     (clk),
        .reset     (reset),
        .start     (start),
        .disarm    (disarm),
        .pass_data (pd),
        .ch_out    (ch_out),
        .busy      (busy),
        .armed     (armed),
        .done      (done)
    );

    remote_arm_sequencer #(
        .WIDTH       (12),
        .CHANNELS    (6),
        .ARM_CH      (2),
        .PRE_CYCLES  (1),
        .HIGH_CYCLES (3),
        .POST_CYCLES (1)
    ) dut2 (
        .clock     (clk),
        .reset     (reset),
        .start     (start2),
        .disarm    (1'b0),
        .pass_data (pd2),
        .ch_out    (ch_out2),
        .busy      (busy2),
        .armed     (armed2),
        .done      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        disarm;
        logic [31:0] pd;
        logic [31:0] exp_ch;
        logic        exp_busy;
        logic        exp_armed;
        logic        exp_done;
    } vec_t;

    vec_t vecs [9];

    localparam logic [31:0] c_SAFE  = 32'h8080_8000;
    localparam logic [71:0] c_SAFE2 = 72'h800800800000800800;
    localparam logic [71:0] c_HIGH2 = 72'h800800800FFF800800;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {ch_out, busy, armed, done} k edges after the edge that accepted start.
    function automatic logic [34:0] exp_at(input int k, input logic [31:0] data);
        logic [7:0] arm;
        if (k >= 48)
            return {data, 1'b0, 1'b1, (k == 48)};
        arm = (k >= 16 && k < 32) ? 8'hFF : 8'h00;
        return {24'h808080, arm, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic run_seq(input logic hold, input int last_k, input string tag);
        start = 1'b1;
        tick();
        start = hold;
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) tick();
            chk($sformatf("%s_k%0d", tag, k), {93'b0, ch_out, busy, armed, done},
                {93'b0, exp_at(k, pd)});
        end
    endtask

    initial begin
        logic [75:0] e2 [7];

        reset  = 1'b1;
        start  = 1'b0;
        disarm = 1'b0;
        start2 = 1'b0;
        pd     = 32'h5566_7788;
        pd2    = 72'h123456789ABCDEF012;
        tick();
        tick();
        chk("reset_dut", {93'b0, ch_out, busy, armed, done}, {93'b0, c_SAFE, 3'b000});
        chk("reset_dut2", {53'b0, ch_out2, busy2, armed2, done2}, {53'b0, c_SAFE2, 3'b000});
        reset = 1'b0;

        // Short-phase configuration: 1 low, 3 high, 1 low, then armed.
        e2[0] = {c_SAFE2, 3'b100};
        e2[1] = {c_HIGH2, 3'b100};
        e2[2] = {c_HIGH2, 3'b100};
        e2[3] = {c_HIGH2, 3'b100};
        e2[4] = {c_SAFE2, 3'b100};
        e2[5] = {pd2,     3'b011};
        e2[6] = {pd2,     3'b010};
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            chk($sformatf("cfg2_k%0d", k), {53'b0, ch_out2, busy2, armed2, done2}, {52'b0, e2[k]});
        end

        // Full default sequence, then one cycle after done.
        run_seq(1'b0, 48, "seq");
        tick();
        chk("seq_after_done", {93'b0, ch_out, busy, armed, done}, {93'b0, pd, 3'b010});

        // Table: pass-through, ignored start, disarm, disarm-wins, restart.
        vecs[0] = '{1'b0, 1'b0, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0102_0304, 32'h0102_0304, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h9999_9999, c_SAFE,        1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h7777_7777, c_SAFE,        1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h6666_6666, c_SAFE,        1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h5555_5555, c_SAFE,        1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h4444_4444, c_SAFE,        1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'h3333_3333, c_SAFE,        1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            start  = vecs[i].start;
            disarm = vecs[i].disarm;
            pd     = vecs[i].pd;
            tick();
            chk($sformatf("vec%0d", i), {93'b0, ch_out, busy, armed, done},
                {93'b0, vecs[i].exp_ch, vecs[i].exp_busy, vecs[i].exp_armed, vecs[i].exp_done});
        end
        start  = 1'b0;
        disarm = 1'b0;
        pd     = 32'h5566_7788;

        // Disarm during the fifth HIGH cycle.
        run_seq(1'b0, 20, "dis");
        disarm = 1'b1;
        tick();
        chk("dis_abort", {93'b0, ch_out, busy, armed, done}, {93'b0, c_SAFE, 3'b000});
        disarm = 1'b0;
        tick();
        chk("dis_idle", {93'b0, ch_out, busy, armed, done}, {93'b0, c_SAFE, 3'b000});

        // Start held high through reset release: one sequence only.
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("hold_reset", {93'b0, ch_out, busy, armed, done}, {93'b0, c_SAFE, 3'b000});
        reset = 1'b0;
        run_seq(1'b1, 51, "hold");
        start  = 1'b0;
        disarm = 1'b1;
        tick();
        chk("hold_disarm", {93'b0, ch_out, busy, armed, done}, {93'b0, c_SAFE, 3'b000});
        disarm = 1'b0;
        run_seq(1'b0, 48, "second");

        // Reset during POST_LOW with start asserted.
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        run_seq(1'b0, 35, "post");
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("post_reset", {93'b0, ch_out, busy, armed, done}, {93'b0, c_SAFE, 3'b000});
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("post_idle", {93'b0, ch_out, busy, armed, done}, {93'b0, c_SAFE, 3'b000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/remote_arm_sequencer.md
REMOTE_ARM_SEQUENCER -- requirements
Module: remote_arm_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each channel value.
REQ-002 Parameter CHANNELS, default 4: number of output channels.
REQ-003 Parameter ARM_CH, default 0: index of the channel that carries the arm pattern.
REQ-004 Parameter PRE_CYCLES, default 16: length of the first low phase, in clock cycles; legal range 1..65535.
REQ-005 Parameter HIGH_CYCLES, default 16: length of the all-ones phase, in clock cycles; legal range 1..65535.
REQ-006 Parameter POST_CYCLES, default 16: length of the second low phase, in clock cycles; legal range 1..65535.
REQ-007 Parameter NEUTRAL, default 2**(WIDTH-1): safe value driven on non-arm channels.
REQ-008 clock  in  1  single clock; all logic is rising-edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 start  in  1  request to begin the arm sequence; sampled only in IDLE.
REQ-011 disarm  in  1  request to abort or disarm; honoured in every non-IDLE state.
REQ-012 pass_data  in  CHANNELS*WIDTH  user channel values; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 ch_out  out  CHANNELS*WIDTH  registered channel outputs, using the same packing as pass_data.
REQ-014 busy  out  1  high while in PRE_LOW, HIGH or POST_LOW.
REQ-015 armed  out  1  high while in ARMED.
REQ-016 done  out  1  one-cycle pulse on the edge that enters ARMED.

Function
REQ-017 The block SHALL implement the states IDLE, PRE_LOW, HIGH, POST_LOW and ARMED, with all outputs registered.
REQ-018 In IDLE, start=1 and disarm=0 at an edge SHALL move the block to PRE_LOW and clear the phase counter.
REQ-019 PRE_LOW SHALL hold for exactly PRE_CYCLES cycles, then move to HIGH and clear the counter.
REQ-020 HIGH SHALL hold for exactly HIGH_CYCLES cycles, then move to POST_LOW and clear the counter.
REQ-021 POST_LOW SHALL hold for exactly POST_CYCLES cycles, then move to ARMED.
REQ-022 The phase counter SHALL be $clog2(max phase+1) bits wide and SHALL never wrap within a phase.
REQ-023 On the arm channel, ch_out SHALL be 0 in IDLE, PRE_LOW and POST_LOW, and all-ones in HIGH.
REQ-024 On all other channels, ch_out SHALL be NEUTRAL in IDLE, PRE_LOW, HIGH and POST_LOW.
REQ-025 ch_out values SHALL change on the same edge as the state change, so each phase value is visible for exactly its phase length.
REQ-026 In ARMED, ch_out SHALL equal pass_data sampled at the previous edge, giving 1-cycle latency on all channels including the arm channel.
REQ-027 disarm=1 in any non-IDLE state SHALL move the block to IDLE on the next edge and drive safe values: arm channel 0, other channels NEUTRAL.
REQ-028 When that disarm occurs, busy, armed and done SHALL all be 0.
REQ-029 start asserted outside IDLE SHALL be ignored; a sequence is never restarted mid-flight.
REQ-030 start and disarm asserted together in IDLE SHALL leave the block in IDLE; disarm wins.
REQ-031 start held high continuously SHALL cause only one sequence per visit to IDLE; re-entry to IDLE via disarm followed by start=1 starts a new sequence.
REQ-032 done SHALL be high for exactly one cycle per successful arm and SHALL never coincide with busy.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE and clear the phase counter.
REQ-034 reset=1 SHALL drive the arm channel to 0 and all other channels to NEUTRAL, and clear busy, armed and done.
REQ-035 reset SHALL take priority over start and disarm.
REQ-036 Reset asserted mid-sequence or in ARMED SHALL abort with no further arm-pattern cycles.
REQ-037 After reset, the outputs SHALL be defined in the same cycle the reset takes effect; the design SHALL not rely on initial values.

Verification
REQ-038 Defaults, start pulse in IDLE -> arm channel reads 0 for 16 cycles, then 0xFF for 16, then 0 for 16; other channels read 0x80 throughout; done high on cycle 49 after start; armed stays high.
REQ-039 ARMED, pass_data=0x11223344 -> ch_out=0x11223344 one cycle later; change pass_data to 0xAABBCCDD -> ch_out follows after one cycle.
REQ-040 disarm at the 5th HIGH cycle -> next edge gives ch_out=0x80808000, busy=0, armed=0, done never pulses.
REQ-041 start held high from reset release -> exactly one sequence; further start pulses in ARMED have no effect; disarm then start -> second full 48-cycle sequence.
REQ-042 start and disarm together in IDLE -> remains IDLE; reset asserted in POST_LOW alongside start -> IDLE with safe values.
REQ-043 Parameters WIDTH=12, CHANNELS=6, ARM_CH=2, PRE_CYCLES=1, HIGH_CYCLES=3, POST_CYCLES=1 -> channel 2 reads 0, then 0xFFF for 3 cycles, then 0, then ARMED; other channels read 0x800.
